// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal transmit FIFO, configurable data width,
// runtime-selectable parity and stop bits, and back-to-back framing.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        CLK16X,
    input  logic [DATA_BITS-1:0]        DIN,
    input  logic                        WRN,
    input  logic                        PARITY_EN,
    input  logic                        PARITY_ODD,
    input  logic                        STOP2,
    output logic                        SDO,
    output logic                        EMPTY,
    output logic                        FULL,
    output logic [$clog2(FIFO_DEPTH):0] LEVEL,
    output logic                        BUSY,
    output logic                        OVERFLOW
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] TICK_LAST  = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    logic                 clk16x_q;
    logic                 tick;
    logic                 tick_last;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] head;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 empty_q, empty_d;
    logic                 full_q, full_d;
    logic                 wr_en;
    logic                 pop;
    state_t               state_q, state_d;
    logic [CW-1:0]        tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 par_en_q, par_en_d;
    logic                 stop2_q, stop2_d;
    logic                 sdo_q, sdo_d;

    assign tick      = CLK16X & ~clk16x_q;
    assign tick_last = tick && (tick_cnt_q == TICK_LAST);
    assign head      = mem_q[rd_ptr_q];

    // A write is refused on the registered FULL even when a pop frees a slot this cycle.
    assign wr_en = ~WRN & ~full_q;

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        par_en_d   = par_en_q;
        stop2_d    = stop2_q;
        sdo_d      = sdo_q;
        pop        = 1'b0;

        if (tick && state_q != IDLE)
            tick_cnt_d = tick_last ? '0 : tick_cnt_q + CW'(1);

        case (state_q)
            IDLE: begin
                if (tick && !empty_q)
                    pop = 1'b1;
            end
            START: begin
                if (tick_last) begin
                    state_d   = DATA;
                    sdo_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick_last) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            sdo_d   = par_q;
                        end else begin
                            state_d = STOP;
                            sdo_d   = 1'b1;
                        end
                    end else begin
                        sdo_d     = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            PARITY: begin
                if (tick_last) begin
                    state_d   = STOP;
                    sdo_d     = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            STOP: begin
                if (tick_last) begin
                    if (stop2_q && bit_cnt_q == '0)
                        bit_cnt_d = BW'(1);
                    else if (!empty_q)
                        pop = 1'b1;
                    else begin
                        state_d = IDLE;
                        sdo_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sdo_d   = 1'b1;
            end
        endcase

        // Frame mode is captured with the word so mid-frame mode changes are ignored.
        if (pop) begin
            state_d    = START;
            sdo_d      = 1'b0;
            tick_cnt_d = '0;
            shift_d    = head;
            par_d      = ^head ^ PARITY_ODD;
            par_en_d   = PARITY_EN;
            stop2_d    = STOP2;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        level_d  = level_q + LW'(wr_en) - LW'(pop);
        empty_d  = (level_d == '0);
        full_d   = (level_d == LEVEL_FULL);
    end

    always_ff @(posedge CLK) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= DIN;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            clk16x_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            par_en_q   <= 1'b0;
            stop2_q    <= 1'b0;
            sdo_q      <= 1'b1;
        end else begin
            clk16x_q   <= CLK16X;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            empty_q    <= empty_d;
            full_q     <= full_d;
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            par_en_q   <= par_en_d;
            stop2_q    <= stop2_d;
            sdo_q      <= sdo_d;
        end
    end

    assign SDO      = sdo_q;
    assign EMPTY    = empty_q;
    assign FULL     = full_q;
    assign LEVEL    = level_q;
    assign BUSY     = (state_q != IDLE) | pop;
    assign OVERFLOW = ~WRN & full_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: expected frames are queued on write and checked
// bit by bit, tick by tick, as the serial line produces them.
module tb_uart_tx_fifo;

    localparam int OS = 16;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
    } frame_t;

    typedef struct {
        logic [7:0] data;
        bit         par_en;
        bit         par_odd;
        bit         stop2;
        bit         exp_par;
        int         exp_nbits;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk16x = 1'b0;
    logic [7:0] din = '0;
    logic       wrn = 1'b1;
    logic       par_en = 1'b0;
    logic       par_odd = 1'b0;
    logic       stop2 = 1'b0;
    logic       sdo, empty, full, busy, overflow;
    logic [4:0] level;

    logic [6:0] din2 = '0;
    logic       wrn2 = 1'b1;
    logic       sdo2, empty2, full2, busy2, overflow2;
    logic [4:0] level2;

    int     n_checks = 0;
    int     n_fails = 0;
    bit     clk16x_run = 1'b1;
    bit     tick_seen = 1'b0;
    bit     c16_prev = 1'b0;
    frame_t sb[$];
    frame_t mon_exp;
    bit     mon_active = 1'b0;
    bit     mon_ok;
    int     mon_idx;
    logic [15:0] mon_rx;
    int     frames_started = 0;

    uart_tx_fifo dut (
        .CLK(clk), .RST_N(rst_n), .CLK16X(clk16x), .DIN(din), .WRN(wrn),
        .PARITY_EN(par_en), .PARITY_ODD(par_odd), .STOP2(stop2),
        .SDO(sdo), .EMPTY(empty), .FULL(full), .LEVEL(level),
        .BUSY(busy), .OVERFLOW(overflow)
    );

    uart_tx_fifo #(.DATA_BITS(7), .FIFO_DEPTH(16), .OVERSAMPLE(8)) dut2 (
        .CLK(clk), .RST_N(rst_n), .CLK16X(clk16x), .DIN(din2), .WRN(wrn2),
        .PARITY_EN(par_en), .PARITY_ODD(par_odd), .STOP2(stop2),
        .SDO(sdo2), .EMPTY(empty2), .FULL(full2), .LEVEL(level2),
        .BUSY(busy2), .OVERFLOW(overflow2)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic frame_t make_frame(input logic [7:0] d, input bit pe, input bit pbit, input int nbits);
        frame_t f;
        int n;
        f.bits  = '0;
        f.nbits = nbits;
        n = 1;
        for (int i = 0; i < 8; i++) begin
            f.bits[n] = d[i];
            n++;
        end
        if (pe) begin
            f.bits[n] = pbit;
            n++;
        end
        for (int i = n; i < nbits; i++)
            f.bits[i] = 1'b1;
        return f;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            tick_seen = 1'b0;
            c16_prev  = 1'b0;
        end else begin
            tick_seen = clk16x & ~c16_prev;
            c16_prev  = clk16x;
        end
    end

    // Frame monitor: one line sample per tick, compared against the queued frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
            sb.delete();
        end else if (tick_seen) begin
            if (mon_active) begin
                if (mon_idx < mon_exp.nbits * OS) begin
                    if (sdo !== mon_exp.bits[mon_idx / OS] || busy !== 1'b1)
                        mon_ok = 1'b0;
                    if (mon_idx % OS == OS / 2)
                        mon_rx[mon_idx / OS] = sdo;
                    mon_idx++;
                end else begin
                    check_output("frame_bits", mon_rx, mon_exp.bits);
                    check_output("frame_timing", mon_ok, 1);
                    check_output("frame_end", {busy, sdo}, (sb.size() != 0) ? 2'b10 : 2'b01);
                    mon_active = 1'b0;
                end
            end
            if (!mon_active && sdo === 1'b0) begin
                check_output("frame_expected", sb.size() != 0, 1);
                if (sb.size() != 0)
                    mon_exp = sb.pop_front();
                else
                    mon_exp = make_frame(8'h00, 1'b0, 1'b0, 10);
                mon_rx     = '0;
                mon_ok     = (busy === 1'b1);
                mon_idx    = 1;
                mon_active = 1'b1;
                frames_started++;
            end
        end
        clk16x = clk16x_run ? ~clk16x : 1'b0;
    end

    task automatic apply_stimulus(input logic [7:0] d);
        @(posedge clk); #1;
        din = d;
        wrn = 1'b0;
        @(posedge clk); #1;
        wrn = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk); #1;
            done = (sb.size() == 0) && !mon_active && (busy === 1'b0);
        end
        check_output(name, done, 1);
    endtask

    task automatic wait_frames(input string name, input int target, input int budget);
        for (int i = 0; i < budget && frames_started < target; i++) begin
            @(negedge clk); #1;
        end
        check_output(name, frames_started >= target, 1);
    endtask

    task automatic next_tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            if (tick_seen) break;
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[7];
        bit          ok;
        bit          found;
        int          base;
        logic [8:0]  exp2;
        logic [8:0]  rx2;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 10};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 11};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 11};
        vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b1, 1'b1, 12};
        vecs[4] = '{8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 12};
        vecs[5] = '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 11};
        vecs[6] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 11};

        repeat (4) @(negedge clk);
        #1;
        check_output("reset_sdo", sdo, 1);
        check_output("reset_empty", empty, 1);
        check_output("reset_full", full, 0);
        check_output("reset_level", level, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_overflow", overflow, 0);
        check_output("reset_sdo2", sdo2, 1);
        rst_n = 1'b1;

        ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk); #1;
            if ({sdo, empty, level, busy} !== {1'b1, 1'b1, 5'd0, 1'b0})
                ok = 1'b0;
        end
        check_output("idle_500_ticks", ok, 1);

        for (int k = 0; k < 7; k++) begin
            par_en  = vecs[k].par_en;
            par_odd = vecs[k].par_odd;
            stop2   = vecs[k].stop2;
            sb.push_back(make_frame(vecs[k].data, vecs[k].par_en, vecs[k].exp_par, vecs[k].exp_nbits));
            apply_stimulus(vecs[k].data);
            for (int i = 0; i < 200 && !mon_active; i++) begin
                @(negedge clk); #1;
            end
            par_en  = ~par_en;
            par_odd = ~par_odd;
            stop2   = ~stop2;
            wait_idle($sformatf("vec%0d_done", k), 2000);
            check_output($sformatf("vec%0d_empty", k), empty, 1);
        end

        par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
        clk16x_run = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        for (int w = 1; w <= 3; w++) begin
            din = 8'(w);
            wrn = 1'b0;
            sb.push_back(make_frame(8'(w), 1'b0, 1'b0, 10));
            @(posedge clk); #1;
        end
        wrn = 1'b1;
        @(negedge clk); #1;
        check_output("b2b_level_3", level, 3);
        base = frames_started;
        clk16x_run = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            wait_frames($sformatf("b2b_frame%0d_start", k), base + k, 2000);
            check_output($sformatf("b2b_level_after_pop%0d", k), level, 5'(3 - k));
        end
        wait_idle("b2b_done", 3000);

        clk16x_run = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;
        for (int i = 1; i <= 17; i++) begin
            din = 8'(i);
            wrn = 1'b0;
            if (i <= 16)
                sb.push_back(make_frame(8'(i), 1'b0, 1'b0, 10));
            @(negedge clk); #1;
            check_output($sformatf("overflow_w%0d", i), overflow, (i == 17) ? 1 : 0);
            @(posedge clk); #1;
        end
        wrn = 1'b1;
        @(negedge clk); #1;
        check_output("overflow_clear", overflow, 0);
        check_output("full_after_16", full, 1);
        check_output("level_after_16", level, 16);
        clk16x_run = 1'b1;
        wait_idle("overflow_drain", 8000);
        check_output("drain_empty", empty, 1);
        check_output("drain_full", full, 0);

        din2 = 7'h55;
        @(posedge clk); #1;
        wrn2 = 1'b0;
        @(posedge clk); #1;
        wrn2 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            next_tick();
            found = (sdo2 === 1'b0);
        end
        check_output("dut2_start", found, 1);
        exp2 = {1'b1, 7'h55, 1'b0};
        rx2  = '0;
        ok   = 1'b1;
        for (int s = 0; s < 72; s++) begin
            if (sdo2 !== exp2[s / 8] || busy2 !== 1'b1)
                ok = 1'b0;
            if (s % 8 == 4)
                rx2[s / 8] = sdo2;
            next_tick();
        end
        check_output("dut2_bits", rx2, exp2);
        check_output("dut2_timing", ok, 1);
        check_output("dut2_end", {busy2, sdo2}, 2'b01);

        sb.push_back(make_frame(8'h00, 1'b0, 1'b0, 10));
        sb.push_back(make_frame(8'h11, 1'b0, 1'b0, 10));
        base = frames_started;
        apply_stimulus(8'h00);
        apply_stimulus(8'h11);
        wait_frames("rst_frame_start", base + 1, 200);
        repeat (80) @(negedge clk);
        #1;
        check_output("pre_reset_sdo", sdo, 0);
        check_output("pre_reset_busy", busy, 1);
        check_output("pre_reset_level", level, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("reset_mid_sdo", sdo, 1);
        check_output("reset_mid_level", level, 0);
        check_output("reset_mid_busy", busy, 0);
        check_output("reset_mid_empty", empty, 1);
        @(negedge clk); #1;
        rst_n = 1'b1;
        base = frames_started;
        repeat (200) @(negedge clk);
        #1;
        check_output("post_reset_no_frame", frames_started, base);
        check_output("post_reset_sdo", sdo, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Adds an internal transmit FIFO, configurable data width, runtime-selectable parity (none/even/odd) and 1 or 2 stop bits, plus back-to-back framing with no idle gap. Sits between the capture/formatting logic and the board serial pin. It uses the same shared 16x baud-rate enable, CLK16X.

Parameters:
DATA_BITS, 8, data bits per frame, legal range 5..9
FIFO_DEPTH, 16, transmit FIFO entries, power of 2, minimum 2
OVERSAMPLE, 16, CLK16X ticks per serial bit period, minimum 2

Ports:
CLK  in  1  system clock
RST_N  in  1  reset; asynchronous assert, active-low
CLK16X  in  1  oversample clock/enable, level; rising edge detected in CLK domain
DIN  in  DATA_BITS  parallel write data
WRN  in  1  write strobe, active low; one FIFO write per CLK cycle while low
PARITY_EN  in  1  1 = append parity bit
PARITY_ODD  in  1  1 = odd parity, 0 = even parity
STOP2  in  1  1 = two stop bits, 0 = one stop bit
SDO  out  1  serial data out, idle high
EMPTY  out  1  FIFO holds no entries
FULL  out  1  FIFO holds FIFO_DEPTH entries
LEVEL  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
BUSY  out  1  a frame is in progress (state != IDLE)
OVERFLOW  out  1  one-CLK pulse when a write is dropped

Behaviour:
- Reset values: SDO=1, EMPTY=1, FULL=0, LEVEL=0, BUSY=0, OVERFLOW=0. FIFO pointers, tick counter, bit counter and shift register are cleared; state=IDLE.
- Reset mid-frame aborts the frame immediately. SDO returns high asynchronously and FIFO contents are discarded.
- Tick definition: tick = CLK16X & ~CLK16X_q, where CLK16X_q is CLK16X registered on CLK (reset 0). A tick is one CLK cycle wide.
- FIFO write: occurs when WRN=0 and FULL=0 (FULL as registered at the start of the cycle). A write while FULL=1 is dropped and OVERFLOW pulses for that cycle. This holds even if a pop happens in the same cycle.
- Simultaneous write and pop: LEVEL is unchanged and both complete. Pointers wrap modulo FIFO_DEPTH.
- FIFO status: EMPTY, FULL and LEVEL are registered and update the cycle after the write/pop.
- A word written into an empty FIFO is not poppable until the following CLK cycle.
- State machine states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with EMPTY=0, pop the head into the shift register. Latch PARITY_EN, PARITY_ODD and STOP2 for the whole frame; the mode inputs are ignored mid-frame. Compute parity = ^data ^ PARITY_ODD. Go to START and clear the tick counter.
  - Each bit occupies exactly OVERSAMPLE ticks. The tick counter increments per tick; the state or bit advances on the tick where counter == OVERSAMPLE-1.
  - START drives SDO=0.
  - DATA sends DATA_BITS bits, LSB first.
  - PARITY (only if PARITY_EN latched) drives the parity bit.
  - STOP drives SDO=1 for 1 or 2 bit periods.
  - End of STOP: if EMPTY=0, pop and go directly to START on the same tick (no idle bit). Otherwise go to IDLE.
- SDO is registered. It changes one CLK after the tick that caused the transition.
- Write-to-start latency: SDO falls one CLK after the first tick that occurs at least one CLK after the write into an idle, empty block.
- Frame length: (1 + DATA_BITS + PARITY_EN + 1 + STOP2) × OVERSAMPLE ticks.
- BUSY=1 from the pop cycle through the last STOP tick. It stays 1 continuously across back-to-back frames.
- CLK16X stopped: the frame freezes in its current state, and SDO holds its value.

Test Plan:
- Reset hold, then release with CLK16X toggling and no writes -> SDO=1, EMPTY=1, LEVEL=0, BUSY=0 for 500 ticks.
- Write 0xA5, 8N1 -> SDO bit sequence 0,1,0,1,0,0,1,0,1,1, each exactly 16 ticks; then BUSY=0 and EMPTY=1.
- Parity: write 0x07 with PARITY_EN=1, PARITY_ODD=0 -> parity bit 1. Same byte with PARITY_ODD=1 -> parity bit 0. With STOP2=1 -> 32 ticks high before IDLE. Toggling mode inputs mid-frame has no effect on that frame.
- Back-to-back: write 0x01, 0x02, 0x03 in consecutive CLK cycles -> three frames with no idle bit between them and BUSY continuously 1; LEVEL reads 3, then 2, 1, 0 at each pop.
- Overflow: keep CLK16X low, write 17 words -> FULL=1 and LEVEL=16 after the 16th write; the 17th write pulses OVERFLOW once and is dropped. Then enable CLK16X -> exactly 16 frames carrying words 1..16.
- Parameter/reset corners:
  - DATA_BITS=7, OVERSAMPLE=8 build: write 0x55 -> 7 data bits at 8 ticks each.
  - Assert RST_N mid-DATA -> SDO=1 immediately and LEVEL=0.
